uwire_receiver: RTL and testbench
=================================

Name: uwire_receiver

Overview:
- MICROWIRE (uWire) responder that oversamples the LMK04816 configuration bus (CLK/DATA/LE) on the fabric clock.
- Deframes each 32-bit word and stores it in a 32-entry shadow register file that mirrors the LMK04816 register map.
- Used in simulation as the clock-cleaner model behind the uWire initiator.
- Used in hardware as a bus monitor that exposes the last programmed configuration and framing statistics to the SoC.

Parameters:
SYNC_STAGES, 2, synchroniser flops per uWire input (min 2)
RESET_BIT, 17, bit index within the 32-bit word that, in an R0 write, triggers soft reset
CNT_WIDTH, 16, width of word and error counters

Ports:
clk  in  1  fabric clock; oversamples the uWire pins
rst_n  in  1  asynchronous active-low reset
uwire_clk_in  in  1  uWire CLK pin (asynchronous to clk)
uwire_data_in  in  1  uWire DATA pin, MSB first
uwire_le_in  in  1  uWire LE pin; rising edge latches the word
word_valid  out  1  one-cycle pulse: a well-formed word was latched
word_addr  out  5  register address of the last valid word (word bits [4:0])
word_data  out  27  payload of the last valid word (word bits [31:5])
frame_err  out  1  one-cycle pulse: LE rose with a bit count other than 32
soft_reset  out  1  one-cycle pulse: R0 write with RESET_BIT set
rd_addr  in  5  shadow register read address
rd_data  out  27  shadow register contents; registered, 1-cycle latency
reg_written  out  32  sticky bitmask: bit n set once Rn has been written
word_count  out  CNT_WIDTH  valid words received, saturating
err_count  out  CNT_WIDTH  framing errors, saturating

Behaviour:
- Reset (rst_n low, asynchronous): all outputs 0; shadow registers 0; shift register 0; bit count 0; synchroniser and edge-history flops 0.
- Input conditioning:
  - Each pin passes through SYNC_STAGES flops, plus one history flop.
  - A rising edge is detected when the synced value is 1 and the history value is 0.
  - Required bus timing: uWire CLK high/low ≥3 clk periods; DATA stable ≥2 clk periods before the CLK rise; LE high ≥3 clk periods.
- Shifting:
  - On a detected CLK rise with synced LE = 0: shift register <= {sr[30:0], synced DATA}, and bit count increments.
  - Bit count saturates at 33 (overflow marker).
  - CLK rises while synced LE = 1 are ignored.
- Latch, on a detected LE rise (cycle D):
  - If a CLK rise is detected in the same cycle, it is ignored (LE is already 1 in the synced view).
  - Bit count == 32: valid word.
    - In cycle D+1: word_valid = 1, and word_addr/word_data are loaded.
    - The shadow register [addr] is written and reg_written[addr] is set.
    - word_count increments (saturating).
  - Bit count != 32 (including 0 and 33): frame_err = 1 in D+1, err_count increments (saturating), no register write, word_addr/word_data unchanged.
  - In every case, bit count and shift register are cleared in D+1.
- Soft reset: a valid word with addr 0 and word bit RESET_BIT = 1 produces, in D+1:
  - word_valid = 1 and soft_reset = 1;
  - all shadow registers cleared to 0 and reg_written cleared to 0;
  - R0 is not stored;
  - word_count and err_count are retained.
- Readback:
  - rd_data <= shadow[rd_addr] every cycle.
  - A write and a read of the same address in the same cycle returns the old value; the new value appears on the next cycle.
- Counters hold at 2^CNT_WIDTH-1 and do not wrap.
- Reset asserted mid-frame: the partial word is discarded. After release, the next LE rise with fewer than 32 bits flags frame_err.

Test Plan:
- Word 0x00140281, 32 CLKs then LE -> word_valid once; word_addr=0x01; word_data=0x000A014; rd_addr=1 gives rd_data=0x000A014 one cycle later; reg_written=0x00000002; word_count=1.
- Write 0x00140281, then 0x00160140 (R0, bit17 set) -> soft_reset and word_valid pulse together; word_data=0x000B00A; rd R1=0; reg_written=0; word_count=2. Then 0x00140140 -> R0 rd_data=0x000A00A; reg_written=0x00000001.
- 31 CLKs then LE -> frame_err one cycle; err_count=1; no write; no word_valid. Then 33 CLKs then LE -> frame_err; err_count=2. Then a good 0x001F001F -> R31=0x000F800.
- Extra CLK pulses while LE high between words -> ignored; the following 32-bit word is decoded correctly with no frame_err.
- rst_n pulsed low after 16 bits of a word -> all outputs 0 immediately. Then 16 more bits and LE -> frame_err (count 16). A full word afterwards decodes normally.
- Force word_count to 0xFFFE, send 3 valid words -> word_count stops at 0xFFFF.

Source files
------------

// File: rtl/uwire_receiver.sv
// uwire_receiver: MICROWIRE responder / bus monitor for the LMK04816 config bus.
// Oversamples CLK/DATA/LE on the fabric clock, deframes 32-bit words MSB
// first, and mirrors them into a 32-entry shadow register file.
module uwire_receiver #(
    parameter int SYNC_STAGES = 2,
    parameter int RESET_BIT   = 17,
    parameter int CNT_WIDTH   = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 uwire_clk_in,
    input  logic                 uwire_data_in,
    input  logic                 uwire_le_in,
    output logic                 word_valid,
    output logic [4:0]           word_addr,
    output logic [26:0]          word_data,
    output logic                 frame_err,
    output logic                 soft_reset,
    input  logic [4:0]           rd_addr,
    output logic [26:0]          rd_data,
    output logic [31:0]          reg_written,
    output logic [CNT_WIDTH-1:0] word_count,
    output logic [CNT_WIDTH-1:0] err_count
);

    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
    // 33 marks "more than 32 bits seen"; the count never goes past it.
    localparam logic [5:0] BITS_FULL = 6'd32;
    localparam logic [5:0] BITS_OVER = 6'd33;

    logic [SYNC_STAGES-1:0] clk_sync;
    logic [SYNC_STAGES-1:0] data_sync;
    logic [SYNC_STAGES-1:0] le_sync;
    logic                   clk_hist;
    logic                   le_hist;

    logic                   clk_s;
    logic                   data_s;
    logic                   le_s;
    logic                   clk_rise;
    logic                   le_rise;

    logic [31:0]            shift_reg;
    logic [5:0]             bit_cnt;

    logic                   good_word;
    logic                   bad_word;
    logic                   soft_hit;

    logic [26:0]            shadow [32];

    // Synchronise each uWire pin and keep one history flop for edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clk_sync  <= '0;
            data_sync <= '0;
            le_sync   <= '0;
            clk_hist  <= 1'b0;
            le_hist   <= 1'b0;
        end else begin
            clk_sync  <= {clk_sync[SYNC_STAGES-2:0], uwire_clk_in};
            data_sync <= {data_sync[SYNC_STAGES-2:0], uwire_data_in};
            le_sync   <= {le_sync[SYNC_STAGES-2:0], uwire_le_in};
            clk_hist  <= clk_sync[SYNC_STAGES-1];
            le_hist   <= le_sync[SYNC_STAGES-1];
        end
    end

    assign clk_s    = clk_sync[SYNC_STAGES-1];
    assign data_s   = data_sync[SYNC_STAGES-1];
    assign le_s     = le_sync[SYNC_STAGES-1];
    assign clk_rise = clk_s & ~clk_hist;
    assign le_rise  = le_s & ~le_hist;

    // A CLK rise coinciding with an LE rise is dropped: le_s is already 1 then.
    assign good_word = le_rise && (bit_cnt == BITS_FULL);
    assign bad_word  = le_rise && (bit_cnt != BITS_FULL);
    assign soft_hit  = good_word && (shift_reg[4:0] == 5'd0) && shift_reg[RESET_BIT];

    // Shift DATA in on CLK rises outside LE; any LE rise restarts the frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift_reg <= '0;
            bit_cnt   <= '0;
        end else if (le_rise) begin
            shift_reg <= '0;
            bit_cnt   <= '0;
        end else if (clk_rise && !le_s) begin
            shift_reg <= {shift_reg[30:0], data_s};
            if (bit_cnt != BITS_OVER) begin
                bit_cnt <= bit_cnt + 6'd1;
            end
        end
    end

    // Word/error pulses, last-word capture and saturating statistics.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            word_valid <= 1'b0;
            frame_err  <= 1'b0;
            soft_reset <= 1'b0;
            word_addr  <= '0;
            word_data  <= '0;
            word_count <= '0;
            err_count  <= '0;
        end else begin
            word_valid <= good_word;
            frame_err  <= bad_word;
            soft_reset <= soft_hit;
            if (good_word) begin
                word_addr <= shift_reg[4:0];
                word_data <= shift_reg[31:5];
                if (word_count != CNT_MAX) begin
                    word_count <= word_count + 1'b1;
                end
            end
            if (bad_word && (err_count != CNT_MAX)) begin
                err_count <= err_count + 1'b1;
            end
        end
    end

    // Shadow register file: a soft reset wipes it instead of storing R0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 32; i++) begin
                shadow[i] <= '0;
            end
            reg_written <= '0;
        end else if (soft_hit) begin
            for (int i = 0; i < 32; i++) begin
                shadow[i] <= '0;
            end
            reg_written <= '0;
        end else if (good_word) begin
            shadow[shift_reg[4:0]]      <= shift_reg[31:5];
            reg_written[shift_reg[4:0]] <= 1'b1;
        end
    end

    // Registered readback; a same-cycle write is seen one cycle later.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data <= '0;
        end else begin
            rd_data <= shadow[rd_addr];
        end
    end

endmodule

// File: tb/tb_uwire_receiver.sv
// Bench for uwire_receiver: drives uWire frames, predicts each latch event
// from the framing rules and checks it in an independent monitor.
module tb_uwire_receiver;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        uclk = 1'b0;
    logic        udata = 1'b0;
    logic        ule = 1'b0;
    logic [4:0]  rd_addr = '0;

    logic        word_valid, frame_err, soft_reset;
    logic [4:0]  word_addr;
    logic [26:0] word_data, rd_data;
    logic [31:0] reg_written;
    logic [15:0] word_count, err_count;

    // narrow-counter instance sharing the same bus, used for saturation
    logic        s_word_valid, s_frame_err, s_soft_reset;
    logic [4:0]  s_word_addr;
    logic [26:0] s_word_data, s_rd_data;
    logic [31:0] s_reg_written;
    logic [1:0]  s_word_count, s_err_count;

    int total = 0;
    int bad = 0;

    typedef struct {
        logic        fe;
        logic        sr;
        logic [4:0]  a;
        logic [26:0] d;
        logic [31:0] rw;
        logic [15:0] wc;
        logic [15:0] ec;
        logic [1:0]  wc2;
        logic [1:0]  ec2;
    } exp_t;
    exp_t exp_q[$];

    // reference state
    logic [26:0] m_sh [32];
    logic [31:0] m_rw;
    logic [15:0] m_wc, m_ec;
    logic [1:0]  m_wc2, m_ec2;
    logic [4:0]  m_a;
    logic [26:0] m_d;

    uwire_receiver dut (
        .clk(clk), .rst_n(rst_n), .uwire_clk_in(uclk), .uwire_data_in(udata),
        .uwire_le_in(ule), .word_valid(word_valid), .word_addr(word_addr),
        .word_data(word_data), .frame_err(frame_err), .soft_reset(soft_reset),
        .rd_addr(rd_addr), .rd_data(rd_data), .reg_written(reg_written),
        .word_count(word_count), .err_count(err_count)
    );

    uwire_receiver #(.CNT_WIDTH(2)) dut_small (
        .clk(clk), .rst_n(rst_n), .uwire_clk_in(uclk), .uwire_data_in(udata),
        .uwire_le_in(ule), .word_valid(s_word_valid), .word_addr(s_word_addr),
        .word_data(s_word_data), .frame_err(s_frame_err), .soft_reset(s_soft_reset),
        .rd_addr(rd_addr), .rd_data(s_rd_data), .reg_written(s_reg_written),
        .word_count(s_word_count), .err_count(s_err_count)
    );

    // clock / reset
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic wait_clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic model_reset();
        for (int i = 0; i < 32; i++) m_sh[i] = '0;
        m_rw = '0; m_wc = '0; m_ec = '0; m_wc2 = '0; m_ec2 = '0;
        m_a = '0; m_d = '0;
    endtask

    // predict the outcome of an LE rise after nbits clocked bits of word w
    task automatic model_frame(input logic [31:0] w, input int nbits);
        exp_t e;
        e.sr = 1'b0;
        if (nbits == 32) begin
            e.fe = 1'b0;
            m_a = w[4:0];
            m_d = w[31:5];
            if (m_a == 5'd0 && w[17]) begin
                e.sr = 1'b1;
                for (int i = 0; i < 32; i++) m_sh[i] = '0;
                m_rw = '0;
            end else begin
                m_sh[m_a] = m_d;
                m_rw[m_a] = 1'b1;
            end
            if (m_wc != 16'hFFFF) m_wc++;
            if (m_wc2 != 2'd3) m_wc2++;
        end else begin
            e.fe = 1'b1;
            if (m_ec != 16'hFFFF) m_ec++;
            if (m_ec2 != 2'd3) m_ec2++;
        end
        e.a = m_a; e.d = m_d; e.rw = m_rw;
        e.wc = m_wc; e.ec = m_ec; e.wc2 = m_wc2; e.ec2 = m_ec2;
        exp_q.push_back(e);
    endtask

    // driver tasks
    task automatic send_bit(input logic b);
        udata = b;
        wait_clks(3);
        uclk = 1'b1;
        wait_clks(3);
        uclk = 1'b0;
    endtask

    task automatic send_bits(input logic [31:0] w, input int first, input int nbits);
        for (int i = first; i < first + nbits; i++) begin
            if (i < 32) send_bit(w[31-i]);
            else send_bit(1'($urandom_range(0, 1)));
        end
    endtask

    task automatic pulse_le(input int extra_clks);
        wait_clks(1);
        ule = 1'b1;
        wait_clks(4);
        for (int i = 0; i < extra_clks; i++) begin
            udata = 1'($urandom_range(0, 1));
            uclk = 1'b1;
            wait_clks(3);
            uclk = 1'b0;
            wait_clks(3);
        end
        ule = 1'b0;
        wait_clks(5);
    endtask

    task automatic send_frame(input logic [31:0] w, input int nbits, input int extra);
        send_bits(w, 0, nbits);
        model_frame(w, nbits);
        pulse_le(extra);
    endtask

    task automatic check_shadow();
        for (int a = 0; a < 32; a++) begin
            @(negedge clk);
            rd_addr = 5'(a);
            @(negedge clk);
            chk($sformatf("rd_data[%0d]", a), 64'(rd_data), 64'(m_sh[a]));
        end
    endtask

    task automatic drain();
        int guard = 0;
        while (exp_q.size() != 0 && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        chk("queue_drained", 64'(exp_q.size()), 64'd0);
    endtask

    // scoreboard monitor
    always @(negedge clk) begin
        if (rst_n && (word_valid || frame_err || soft_reset ||
                      s_word_valid || s_frame_err || s_soft_reset)) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_event", {61'd0, word_valid, frame_err, soft_reset}, 64'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("word_valid", 64'(word_valid), 64'(!e.fe));
                chk("frame_err", 64'(frame_err), 64'(e.fe));
                chk("soft_reset", 64'(soft_reset), 64'(e.sr));
                chk("word_addr", 64'(word_addr), 64'(e.a));
                chk("word_data", 64'(word_data), 64'(e.d));
                chk("reg_written", 64'(reg_written), 64'(e.rw));
                chk("word_count", 64'(word_count), 64'(e.wc));
                chk("err_count", 64'(err_count), 64'(e.ec));
                chk("small_valid", 64'(s_word_valid), 64'(!e.fe));
                chk("small_word_count", 64'(s_word_count), 64'(e.wc2));
                chk("small_err_count", 64'(s_err_count), 64'(e.ec2));
            end
        end
    end

    initial begin
        logic [31:0] w;
        int nb;
        model_reset();
        wait_clks(3);
        chk("reset_word_valid", 64'(word_valid), 64'd0);
        chk("reset_word_count", 64'(word_count), 64'd0);
        rst_n = 1'b1;
        wait_clks(3);
        chk("idle_reg_written", 64'(reg_written), 64'd0);
        chk("idle_rd_data", 64'(rd_data), 64'd0);

        // basic word, then a soft reset, then R0 stored
        send_frame(32'h00140281, 32, 0);
        drain();
        check_shadow();
        send_frame(32'h00160140, 32, 0);
        drain();
        check_shadow();
        send_frame(32'h00140140, 32, 0);
        drain();
        check_shadow();

        // short / long frames, then R31
        send_frame(32'hDEADBEEF, 31, 0);
        send_frame(32'h12345678, 33, 0);
        send_frame(32'h001F001F, 32, 0);
        send_frame(32'h0, 0, 0);
        drain();
        check_shadow();

        // CLK activity while LE is high is ignored
        send_frame(32'h00ABCDE3, 32, 3);
        send_frame(32'h7654321A, 32, 0);
        drain();

        // reset in the middle of a frame
        w = 32'hCAFE0007;
        send_bits(w, 0, 16);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_reset_outputs", {word_valid, frame_err, soft_reset, word_addr, word_data},
            64'd0);
        chk("mid_reset_rd_data", 64'(rd_data), 64'd0);
        chk("mid_reset_reg_written", 64'(reg_written), 64'd0);
        chk("mid_reset_counts", {word_count, err_count}, 64'd0);
        model_reset();
        wait_clks(3);
        rst_n = 1'b1;
        wait_clks(2);
        send_bits(w, 16, 16);
        model_frame(w, 16);
        pulse_le(0);
        send_frame(32'h00140281, 32, 0);
        drain();
        check_shadow();

        // randomized frames
        for (int k = 0; k < 30; k++) begin
            w = $urandom;
            if ($urandom_range(0, 7) == 0) w[4:0] = 5'd0;
            nb = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 36)) : 32;
            send_frame(w, nb, ($urandom_range(0, 4) == 0) ? 2 : 0);
        end
        drain();
        check_shadow();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
